placement_wirelength_eval: RTL and testbench
============================================

Name: placement_wirelength_eval

Overview:
- Downstream stage of the random placer; started once the placer reports completion.
- Walks the edge list and fetches both endpoint coordinates from the X/Y position RAMs.
- Accumulates total Manhattan wirelength (sum |dx|+|dy|-1) and 1-hop cost (sum ceil(|dx|/2)+ceil(|dy|/2)-1).
- Reports results with a start/done handshake and flags edges whose endpoints were never placed.

Parameters:
- N_EDGE, 52, number of edges to evaluate.
- DATA_W, 32, width of memory words and accumulators.
- EDGE_AW, 8, edge ROM address width.
- POS_AW, 7, position RAM address width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin evaluation; sampled only in IDLE
- busy  out  1  high from first cycle after accepted start until DONE
- done  out  1  one-cycle pulse; results valid from this cycle
- edge_rd  out  1  edge ROM read enable (drives both A and B ROMs)
- edge_addr  out  EDGE_AW  edge index
- edge_a  in  DATA_W  node A id
- edge_b  in  DATA_W  node B id
- pos_rd  out  1  position RAM read enable (drives X and Y RAMs)
- pos_addr  out  POS_AW  node id
- pos_x  in  DATA_W  signed X coordinate; all-ones means unplaced
- pos_y  in  DATA_W  signed Y coordinate; all-ones means unplaced
- cost_sum  out  DATA_W  signed wirelength accumulator
- cost_1hop  out  DATA_W  signed 1-hop accumulator
- err_unplaced  out  1  sticky: at least one skipped edge
- edges_skipped  out  EDGE_AW  count of skipped edges

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; edge_addr=0; pos_addr=0.
- Memory timing: data for a read issued in cycle t is sampled in cycle t+2 (one wait cycle).
- Read enables are single-cycle pulses.
- FSM: IDLE -> EREQ -> EWAIT -> AREQ -> AWAIT -> BREQ -> BWAIT -> DIFF -> ACC -> (EREQ | DONE) -> IDLE.
  - IDLE: on start=1, clear accumulators, err_unplaced, edges_skipped and edge index i. Go to EREQ, or to DONE if N_EDGE==0.
  - EREQ: edge_rd=1, edge_addr=i.
  - AREQ: latch a=edge_a, b=edge_b; pos_rd=1, pos_addr=a.
  - BREQ: latch ax,ay; pos_rd=1, pos_addr=b.
  - DIFF: latch bx,by; dx=|ax-bx|, dy=|ay-by| (two's-complement abs, DATA_W wide). Set skip if any of ax,ay,bx,by equals all-ones.
  - ACC, skip=0: cost_sum += dx+dy-1; cost_1hop += (dx>>1)+dx[0]+(dy>>1)+dy[0]-1.
  - ACC, skip=1: accumulators unchanged; err_unplaced<=1; edges_skipped++.
  - ACC exit: i++; if i==N_EDGE-1 go to DONE, else EREQ.
  - DONE: done=1, busy=0; next IDLE.
- Latency: 8 cycles per edge. done is asserted 8*N_EDGE+1 rising edges after the edge that samples start.
- Accumulators wrap modulo 2^DATA_W; no saturation.
- Results hold until the next accepted start.
- start while busy or in DONE: ignored.
- start held high continuously: re-triggers from IDLE each pass.

Optional Feature:
- Macro EVAL_MAXDIST_EN.
- Defined: adds output max_dist (DATA_W), reset 0, cleared on accepted start. In ACC with skip=0: if dx+dy > max_dist, max_dist <= dx+dy.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package placement_eval_pkg holds:
  - FSM state enum
  - UNPLACED constant (all-ones, DATA_W)
  - default DATA_W/EDGE_AW/POS_AW
  - WAIT_CYCLES=1 memory-latency constant, shared with the placer
- One sub-module, manhattan_dist: combinational abs-diff of two coordinate pairs, producing dx, dy, dx+dy and the 1-hop term. Instantiated once in DIFF/ACC.

Test Plan:
- N_EDGE=1, edge (0,1), pos0=(0,0), pos1=(3,2) -> done at edge 9 after start; cost_sum=4, cost_1hop=2, err_unplaced=0.
- Edges with pos=(5,0),(2,6) and (1,1),(1,2), N_EDGE=2 -> cost_sum=8+0=8, cost_1hop=4+0=4; done at edge 17.
- Node 3 with pos_x=32'hFFFFFFFF in one of 3 edges -> err_unplaced=1, edges_skipped=1; sums include only the other two edges.
- Assert reset during BWAIT of edge 2 -> busy, done and accumulators 0 immediately (async); a new start gives a correct full result.
- Pulse start during ACC -> no restart; single done; results unchanged versus an unperturbed run.
- EVAL_MAXDIST_EN defined, distances 3, 9, 4 -> max_dist=9; undefined -> build without the port passes the same sum checks.

Source files
------------

// File: rtl/placement_eval_pkg.sv
// placement_eval_pkg: shared FSM states, unplaced marker and default widths for the wirelength evaluator
package placement_eval_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_EDGE_AW = 8;
  localparam int DEF_POS_AW = 7;
  localparam int WAIT_CYCLES = 1;
  localparam logic [DEF_DATA_W-1:0] UNPLACED = '1;
  typedef enum logic [3:0] {
    S_IDLE, S_EREQ, S_EWAIT, S_AREQ, S_AWAIT, S_BREQ, S_BWAIT, S_DIFF, S_ACC, S_DONE
  } state_t;
endpackage

// File: rtl/manhattan_dist.sv
// manhattan_dist: two's-complement abs difference of two points, their sum and the ceil-halved 1-hop term
module manhattan_dist
  import placement_eval_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] ax,
  input  logic [DATA_W-1:0] ay,
  input  logic [DATA_W-1:0] bx,
  input  logic [DATA_W-1:0] by,
  output logic [DATA_W-1:0] dx,
  output logic [DATA_W-1:0] dy,
  output logic [DATA_W-1:0] dsum,
  output logic [DATA_W-1:0] hop
);
  logic [DATA_W-1:0] ddx, ddy;
  // abs of signed differences; ceil(d/2) is (d>>1) plus the dropped low bit
  always_comb begin
    ddx = ax - bx;
    ddy = ay - by;
    dx = ddx[DATA_W-1] ? -ddx : ddx;
    dy = ddy[DATA_W-1] ? -ddy : ddy;
    dsum = dx + dy;
    hop = (dx >> 1) + DATA_W'(dx[0]) + (dy >> 1) + DATA_W'(dy[0]);
  end
endmodule

// File: rtl/placement_wirelength_eval.sv
// placement_wirelength_eval: walks the edge list and accumulates Manhattan and 1-hop wirelength (optional EVAL_MAXDIST_EN adds max_dist)
module placement_wirelength_eval
  import placement_eval_pkg::*;
#(
  parameter int N_EDGE = 52,
  parameter int DATA_W = DEF_DATA_W,
  parameter int EDGE_AW = DEF_EDGE_AW,
  parameter int POS_AW = DEF_POS_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               edge_rd,
  output logic [EDGE_AW-1:0] edge_addr,
  input  logic [DATA_W-1:0]  edge_a,
  input  logic [DATA_W-1:0]  edge_b,
  output logic               pos_rd,
  output logic [POS_AW-1:0]  pos_addr,
  input  logic [DATA_W-1:0]  pos_x,
  input  logic [DATA_W-1:0]  pos_y,
  output logic [DATA_W-1:0]  cost_sum,
  output logic [DATA_W-1:0]  cost_1hop,
  output logic               err_unplaced,
  output logic [EDGE_AW-1:0] edges_skipped
`ifdef EVAL_MAXDIST_EN
  ,
  output logic [DATA_W-1:0]  max_dist
`endif
);
  localparam logic [DATA_W-1:0] UNP = {DATA_W{UNPLACED[0]}};
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
  state_t state, state_n;
  logic [EDGE_AW-1:0] i;
  logic [POS_AW-1:0] b;
  logic [DATA_W-1:0] ax, ay, bx, by, dx, dy, dsum, hop;
  logic skip, last, unused_bits;
  assign unused_bits = ^{edge_a[DATA_W-1:POS_AW], edge_b[DATA_W-1:POS_AW], dx, dy};
  assign last = i == EDGE_AW'(N_EDGE - 1);
  manhattan_dist #(.DATA_W(DATA_W)) u_dist (
    .ax(ax), .ay(ay), .bx(bx), .by(by), .dx(dx), .dy(dy), .dsum(dsum), .hop(hop)
  );
  // next state and the memory-request strobes decoded from the current state
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? ((N_EDGE == 0) ? S_DONE : S_EREQ) : S_IDLE;
      S_EREQ:  state_n = S_EWAIT;
      S_EWAIT: state_n = S_AREQ;
      S_AREQ:  state_n = S_AWAIT;
      S_AWAIT: state_n = S_BREQ;
      S_BREQ:  state_n = S_BWAIT;
      S_BWAIT: state_n = S_DIFF;
      S_DIFF:  state_n = S_ACC;
      S_ACC:   state_n = last ? S_DONE : S_EREQ;
      default: state_n = S_IDLE;
    endcase
    busy = state != S_IDLE && state != S_DONE;
    done = state == S_DONE;
    edge_rd = state == S_EREQ;
    edge_addr = i;
    pos_rd = state == S_AREQ || state == S_BREQ;
    pos_addr = (state == S_AREQ) ? edge_a[POS_AW-1:0] : b;
  end
  // state register, operand latches and result accumulators
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      i <= '0;
      b <= '0;
      ax <= '0;
      ay <= '0;
      bx <= '0;
      by <= '0;
      skip <= 1'b0;
      cost_sum <= '0;
      cost_1hop <= '0;
      err_unplaced <= 1'b0;
      edges_skipped <= '0;
`ifdef EVAL_MAXDIST_EN
      max_dist <= '0;
`endif
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (start) begin
          i <= '0;
          cost_sum <= '0;
          cost_1hop <= '0;
          err_unplaced <= 1'b0;
          edges_skipped <= '0;
`ifdef EVAL_MAXDIST_EN
          max_dist <= '0;
`endif
        end
        S_AREQ: b <= edge_b[POS_AW-1:0];
        S_BREQ: begin
          ax <= pos_x;
          ay <= pos_y;
        end
        S_DIFF: begin
          bx <= pos_x;
          by <= pos_y;
          skip <= ax == UNP || ay == UNP || pos_x == UNP || pos_y == UNP;
        end
        S_ACC: begin
          i <= i + EDGE_AW'(1);
          if (skip) begin
            err_unplaced <= 1'b1;
            edges_skipped <= edges_skipped + EDGE_AW'(1);
          end else begin
            cost_sum <= cost_sum + dsum - ONE;
            cost_1hop <= cost_1hop + hop - ONE;
`ifdef EVAL_MAXDIST_EN
            if (dsum > max_dist) max_dist <= dsum;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_placement_wirelength_eval.sv
// tb_placement_wirelength_eval: randomized and directed checks of the wirelength evaluator against a reference model
module tb_placement_wirelength_eval;
  localparam int NE = 3;
  localparam int LAT = 8 * NE + 1;
  localparam logic [31:0] UNPL = 32'hFFFF_FFFF;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic busy, done, edge_rd, pos_rd, err_unplaced;
  logic [7:0] edge_addr, edges_skipped;
  logic [6:0] pos_addr;
  logic [31:0] ea, eb, px, py, cost_sum, cost_1hop;
`ifdef EVAL_MAXDIST_EN
  logic [31:0] max_dist;
`endif
  logic [31:0] rom_a[256], rom_b[256], ram_x[128], ram_y[128];
  int checks = 0, failures = 0;

  placement_wirelength_eval #(.N_EDGE(NE)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .edge_rd(edge_rd), .edge_addr(edge_addr), .edge_a(ea), .edge_b(eb),
    .pos_rd(pos_rd), .pos_addr(pos_addr), .pos_x(px), .pos_y(py),
    .cost_sum(cost_sum), .cost_1hop(cost_1hop),
    .err_unplaced(err_unplaced), .edges_skipped(edges_skipped)
`ifdef EVAL_MAXDIST_EN
    , .max_dist(max_dist)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (edge_rd) begin
      ea <= rom_a[edge_addr];
      eb <= rom_b[edge_addr];
    end
    if (pos_rd) begin
      px <= ram_x[pos_addr];
      py <= ram_y[pos_addr];
    end
  end

  function automatic void model(output logic [31:0] s, output logic [31:0] h,
                                output logic [31:0] m, output int sk);
    s = 0; h = 0; m = 0; sk = 0;
    for (int e = 0; e < NE; e++) begin
      logic [31:0] ax, ay, bx, by;
      longint dx, dy;
      ax = ram_x[rom_a[e][6:0]]; ay = ram_y[rom_a[e][6:0]];
      bx = ram_x[rom_b[e][6:0]]; by = ram_y[rom_b[e][6:0]];
      if (ax == UNPL || ay == UNPL || bx == UNPL || by == UNPL) sk++;
      else begin
        dx = longint'($signed(ax)) - longint'($signed(bx));
        dy = longint'($signed(ay)) - longint'($signed(by));
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        s = s + 32'(dx + dy - 1);
        h = h + 32'((dx + 1) / 2 + (dy + 1) / 2 - 1);
        if (dx + dy > longint'(m)) m = 32'(dx + dy);
      end
    end
  endfunction

  task automatic load_directed();
    for (int n = 0; n < 128; n++) begin ram_x[n] = 0; ram_y[n] = 0; end
    ram_x[1] = 3; ram_y[1] = 2;
    ram_x[2] = 5; ram_y[2] = 0;
    ram_x[3] = 2; ram_y[3] = 6;
    ram_x[4] = 1; ram_y[4] = 1;
    ram_x[5] = 1; ram_y[5] = 2;
    rom_a[0] = 0; rom_b[0] = 1;
    rom_a[1] = 2; rom_b[1] = 3;
    rom_a[2] = 4; rom_b[2] = 5;
  endtask

  task automatic run(output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, edge_rd, pos_rd, err_unplaced} !== 5'b0 || edge_addr !== 8'd0 || pos_addr !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b/%0d/%0d exp=0", {busy, done, edge_rd, pos_rd, err_unplaced}, edge_addr, pos_addr);
    end
    checks++;
    if (cost_sum !== 32'd0 || cost_1hop !== 32'd0 || edges_skipped !== 8'd0) begin
      failures++;
      $display("FAIL reset_acc got=%0d/%0d/%0d exp=0", cost_sum, cost_1hop, edges_skipped);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    load_directed();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || edge_rd !== 1'b1 || edge_addr !== 8'd0) begin
      failures++;
      $display("FAIL first_req got=%b%b/%0d exp=11/0", busy, edge_rd, edge_addr);
    end
    lat = -1;
    for (int k = 2; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    checks++;
    if (lat != LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_at_done got=%b exp=0", busy); end
    checks++;
    if (cost_sum !== 32'd12 || cost_1hop !== 32'd6) begin
      failures++;
      $display("FAIL basic_sums got=%0d/%0d exp=12/6", cost_sum, cost_1hop);
    end
    checks++;
    if (err_unplaced !== 1'b0 || edges_skipped !== 8'd0) begin
      failures++;
      $display("FAIL basic_err got=%b/%0d exp=0/0", err_unplaced, edges_skipped);
    end
`ifdef EVAL_MAXDIST_EN
    checks++;
    if (max_dist !== 32'd9) begin failures++; $display("FAIL basic_max got=%0d exp=9", max_dist); end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_unplaced();
    int lat;
    load_directed();
    ram_x[3] = UNPL;
    run(lat);
    checks++;
    if (lat != LAT) begin failures++; $display("FAIL unpl_latency got=%0d exp=%0d", lat, LAT); end
    checks++;
    if (cost_sum !== 32'd4 || cost_1hop !== 32'd2) begin
      failures++;
      $display("FAIL unpl_sums got=%0d/%0d exp=4/2", cost_sum, cost_1hop);
    end
    checks++;
    if (err_unplaced !== 1'b1 || edges_skipped !== 8'd1) begin
      failures++;
      $display("FAIL unpl_err got=%b/%0d exp=1/1", err_unplaced, edges_skipped);
    end
  endtask

  task automatic test_random();
    logic [31:0] es, eh, em;
    int esk, lat;
    for (int it = 0; it < 5; it++) begin
      for (int n = 0; n < 128; n++) begin
        ram_x[n] = 32'($urandom_range(0, 4000)) - 32'd2000;
        ram_y[n] = 32'($urandom_range(0, 4000)) - 32'd2000;
        if ($urandom_range(0, 15) == 0) ram_y[n] = UNPL;
      end
      for (int e = 0; e < NE; e++) begin
        rom_a[e] = 32'($urandom_range(0, 127));
        rom_b[e] = 32'($urandom_range(0, 127));
      end
      model(es, eh, em, esk);
      run(lat);
      checks++;
      if (lat != LAT) begin failures++; $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, lat, LAT); end
      checks++;
      if (cost_sum !== es || cost_1hop !== eh) begin
        failures++;
        $display("FAIL rand_sums it=%0d got=%0d/%0d exp=%0d/%0d", it, cost_sum, cost_1hop, es, eh);
      end
      checks++;
      if (edges_skipped !== 8'(esk) || err_unplaced !== (esk != 0)) begin
        failures++;
        $display("FAIL rand_skip it=%0d got=%0d/%b exp=%0d", it, edges_skipped, err_unplaced, esk);
      end
`ifdef EVAL_MAXDIST_EN
      checks++;
      if (max_dist !== em) begin failures++; $display("FAIL rand_max it=%0d got=%0d exp=%0d", it, max_dist, em); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    load_directed();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (13) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cost_sum !== 32'd0 || cost_1hop !== 32'd0) begin
      failures++;
      $display("FAIL async_reset got=%b%b/%0d/%0d exp=00/0/0", busy, done, cost_sum, cost_1hop);
    end
    @(negedge clk);
    reset = 1'b0;
    run(lat);
    checks++;
    if (lat != LAT || cost_sum !== 32'd12 || cost_1hop !== 32'd6) begin
      failures++;
      $display("FAIL after_reset got=%0d/%0d/%0d exp=%0d/12/6", lat, cost_sum, cost_1hop, LAT);
    end
  endtask

  task automatic test_start_in_acc();
    int ndone, first;
    load_directed();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    first = -1;
    for (int k = 9; k <= 70; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (ndone != 1 || first != LAT) begin
      failures++;
      $display("FAIL acc_start got=%0d dones at %0d exp=1 at %0d", ndone, first, LAT);
    end
    checks++;
    if (cost_sum !== 32'd12 || cost_1hop !== 32'd6) begin
      failures++;
      $display("FAIL acc_sums got=%0d/%0d exp=12/6", cost_sum, cost_1hop);
    end
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    load_directed();
    @(negedge clk);
    start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    gap = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin gap = k; break; end
    end
    start = 1'b0;
    checks++;
    if (gap != LAT + 1) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", gap, LAT + 1); end
    checks++;
    if (cost_sum !== 32'd12 || cost_1hop !== 32'd6) begin
      failures++;
      $display("FAIL b2b_sums got=%0d/%0d exp=12/6", cost_sum, cost_1hop);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cost_sum !== 32'd12 || cost_1hop !== 32'd6) begin
      failures++;
      $display("FAIL hold got=%b%b/%0d/%0d exp=00/12/6", busy, done, cost_sum, cost_1hop);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unplaced();
    test_random();
    test_reset_mid();
    test_start_in_acc();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
